// File: rtl/led_pkg.sv
// Shared constants and types for the LED colour output path.
package led_pkg;

    localparam int PWM_BITS    = 8;
    localparam int PHASE_G_DEF = 85;
    localparam int PHASE_B_DEF = 170;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb8_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output pin: compares the shared period counter, shifted by a fixed
// phase offset, against the channel duty and registers the result.
module pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PHASE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pin
);

    localparam logic [PWM_BITS-1:0] PHASE_OFS = PWM_BITS'(PHASE % (1 << PWM_BITS));

    logic [PWM_BITS-1:0] phase_cnt;

    // Modulo-256 subtraction staggers the rising edge by PHASE ticks.
    assign phase_cnt = pwm_cnt - PHASE_OFS;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin <= 1'b0;
        end else begin
            pin <= (phase_cnt < duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED output stage: double-buffered duty triple, brightness scaling at
// PWM period boundaries, and three phase-staggered PWM channels.
module rgb_pwm_driver
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 47,
    parameter int unsigned PHASE_G  = PHASE_G_DEF,
    parameter int unsigned PHASE_B  = PHASE_B_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PWM_BITS-1:0] in_r,
    input  logic [PWM_BITS-1:0] in_g,
    input  logic [PWM_BITS-1:0] in_b,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output logic                period_start
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                wrap;
    logic                xfer;
    logic                commit;
    logic                pend_full;
    rgb8_t               pend;
    rgb8_t               active;

    // (duty * (level + 1)) >> 8: full scale maps 255 to 255, level 0 to 0.
    function automatic logic [PWM_BITS-1:0] scale_duty(
        input logic [PWM_BITS-1:0] duty,
        input logic [PWM_BITS-1:0] level
    );
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, duty} * ({{PWM_BITS{1'b0}}, level} + 16'd1);
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign tick     = (pre == PRE_LAST);
    assign wrap     = tick && (pwm_cnt == CNT_LAST);
    assign in_ready = !pend_full;
    assign xfer     = in_valid && in_ready;
    // A transfer needs an empty buffer and a commit needs a full one, so the
    // two are mutually exclusive in any given cycle.
    assign commit   = wrap && pend_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre          <= '0;
            pwm_cnt      <= '0;
            pend_full    <= 1'b0;
            active       <= '0;
            period_start <= 1'b0;
        end else begin
            pre          <= tick ? '0 : pre + 1'b1;
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (commit) begin
                active.r  <= scale_duty(pend.r, brightness);
                active.g  <= scale_duty(pend.g, brightness);
                active.b  <= scale_duty(pend.b, brightness);
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending data is qualified by pend_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            pend.r <= in_r;
            pend.g <= in_g;
            pend.b <= in_b;
        end
    end

    pwm_channel #(.PHASE(0)) u_chan_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .duty    (active.r),
        .pin     (RGB_R)
    );

    pwm_channel #(.PHASE(PHASE_G)) u_chan_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .duty    (active.g),
        .pin     (RGB_G)
    );

    pwm_channel #(.PHASE(PHASE_B)) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .duty    (active.b),
        .pin     (RGB_B)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver with TICK_DIV = 2 (512-cycle PWM period).
module tb_rgb_pwm_driver;

    localparam int TD     = 2;
    localparam int PERIOD = 256 * TD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r, in_g, in_b;
    logic [7:0] brightness;
    logic       RGB_R, RGB_G, RGB_B;
    logic       period_start;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_r, cnt_g, cnt_b;
    int rise_r, rise_g, rise_b;

    always #5 clk = ~clk;

    rgb_pwm_driver #(
        .TICK_DIV (TD),
        .PHASE_G  (85),
        .PHASE_B  (170)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r         (in_r),
        .in_g         (in_g),
        .in_b         (in_b),
        .brightness   (brightness),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B),
        .period_start (period_start)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called on a falling edge; leaves the bench on a falling edge.
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int waited = 0;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_val("send_ready", int'(in_ready), 1);
        in_r     = r;
        in_g     = g;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts high cycles and the last rising-edge index over one period,
    // samples 1..PERIOD after the period_start cycle (index 0).
    task automatic measure(input string tag, input bit wait_ps,
                           input int er, input int eg, input int eb);
        int   waited = 0;
        logic pr, pg, pb;
        if (wait_ps) begin
            @(negedge clk);
            while (!period_start && waited < 3 * PERIOD) begin
                @(negedge clk);
                waited++;
            end
            check_val({tag, "_ps"}, int'(period_start), 1);
            if (!period_start) return;
        end
        pr = RGB_R; pg = RGB_G; pb = RGB_B;
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        rise_r = -1; rise_g = -1; rise_b = -1;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (RGB_R) cnt_r++;
            if (RGB_G) cnt_g++;
            if (RGB_B) cnt_b++;
            if (RGB_R && !pr) rise_r = i;
            if (RGB_G && !pg) rise_g = i;
            if (RGB_B && !pb) rise_b = i;
            pr = RGB_R; pg = RGB_G; pb = RGB_B;
        end
        check_val({tag, "_r_high"}, cnt_r, er);
        check_val({tag, "_g_high"}, cnt_g, eg);
        check_val({tag, "_b_high"}, cnt_b, eb);
        check_val({tag, "_next_ps"}, int'(period_start), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_r       = 8'd99;
        in_g       = 8'd99;
        in_b       = 8'd99;
        brightness = 8'd255;

        // Reset with in_valid asserted: nothing may be captured.
        repeat (3) @(negedge clk);
        check_val("rst_r", int'(RGB_R), 0);
        check_val("rst_g", int'(RGB_G), 0);
        check_val("rst_b", int'(RGB_B), 0);
        check_val("rst_ps", int'(period_start), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_val("rst_ready", int'(in_ready), 1);
        measure("idle", 1'b1, 0, 0, 0);
        check_val("idle_ready", int'(in_ready), 1);

        // Full red at full brightness.
        send(8'd255, 8'd0, 8'd0);
        measure("red", 1'b1, 510, 0, 0);
        check_val("red_rise_r", rise_r, 1);

        // Scaling: 200 at brightness 128 -> 100 -> 200 high cycles.
        brightness = 8'd128;
        send(8'd200, 8'd200, 8'd200);
        measure("scale", 1'b1, 200, 200, 200);
        repeat (100) @(negedge clk);
        brightness = 8'd255;
        measure("bright_hold", 1'b1, 200, 200, 200);

        // Brightness is sampled at commit, not at transfer.
        brightness = 8'd64;
        send(8'd200, 8'd200, 8'd200);
        brightness = 8'd255;
        measure("rescale", 1'b1, 400, 400, 400);

        // Back-pressure: B waits for the boundary that commits A.
        send(8'd10, 8'd20, 8'd30);
        in_r     = 8'd40;
        in_g     = 8'd50;
        in_b     = 8'd60;
        in_valid = 1'b1;
        check_val("bp_ready_low", int'(in_ready), 0);
        waited = 0;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_val("bp_ready_high", int'(in_ready), 1);
        check_val("bp_release_ps", int'(period_start), 1);
        measure("bp_a", 1'b0, 20, 40, 60);
        measure("bp_b", 1'b0, 80, 100, 120);
        measure("bp_hold", 1'b0, 80, 100, 120);
        check_val("bp_ready_end", int'(in_ready), 1);

        // Phase stagger with all duties 128.
        send(8'd128, 8'd128, 8'd128);
        measure("phase", 1'b1, 256, 256, 256);
        check_val("phase_rise_r", rise_r, 1);
        check_val("phase_rise_g", rise_g, 171);
        check_val("phase_rise_b", rise_b, 341);

        // Mid-operation reset with a pending entry and nonzero active duties.
        send(8'd50, 8'd50, 8'd50);
        check_val("mid_pend_ready", int'(in_ready), 0);
        repeat (20) @(negedge clk);
        check_val("mid_pre_r", int'(RGB_R), 1);
        check_val("mid_pre_b", int'(RGB_B), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_r", int'(RGB_R), 0);
        check_val("mid_rst_g", int'(RGB_G), 0);
        check_val("mid_rst_b", int'(RGB_B), 0);
        check_val("mid_rst_ps", int'(period_start), 0);
        check_val("mid_rst_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        measure("post_rst", 1'b1, 0, 0, 0);
        check_val("post_rst_ready", int'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
